// File: rtl/apb_irq_pkg.sv
// apb_irq_pkg: register map, FSM states and id width for the APB interrupt controller
package apb_irq_pkg;
  localparam int IRQ_ID_W = 5;
  localparam logic [2:0] REG_MASK = 3'd0;
  localparam logic [2:0] REG_PEND = 3'd1;
  localparam logic [2:0] REG_CLR  = 3'd2;
  localparam logic [2:0] REG_SET  = 3'd3;
  localparam logic [2:0] REG_ID   = 3'd4;
  typedef enum logic {IDLE, REQ} state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
module irq_prio_enc
  import apb_irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          vec,
  output logic [IRQ_ID_W-1:0]   idx,
  output logic                  valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? IRQ_ID_W'(i) : idx;
  end
  assign valid = |vec;
endmodule

// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl: edge-triggered interrupt controller with APB mask/pending/clear/set/id registers
module apb_irq_ctrl
  import apb_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int IRQ_CNT        = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [IRQ_CNT-1:0]        irq_i,
  output logic                      irq_o,
  output logic [IRQ_ID_W-1:0]       irq_id_o,
  input  logic                      irq_ack_i
);
  logic [IRQ_CNT-1:0]  mask_q, mask_d, pend_q, pend_d, irq_q, irq_d;
  logic [IRQ_CNT-1:0]  edge_v, set_v, clr_v, id_oh, act_v, wdata;
  logic [IRQ_ID_W-1:0] id_q, id_d, enc_idx;
  logic [31:0]         rdata;
  logic [2:0]          off;
  logic                enc_vld, acc, bad, wr;
  logic                unused_ok;
  state_e              state_q, state_d;

  assign off       = PADDR[4:2];
  assign wdata     = PWDATA[IRQ_CNT-1:0];
  assign acc       = PSEL & PENABLE;
  assign bad       = acc & ((off > REG_ID) | (PWRITE & (off == REG_PEND || off == REG_ID)));
  assign wr        = acc & PWRITE & ~bad;
  assign unused_ok = ^{PADDR, PWDATA};

  irq_prio_enc #(.N(IRQ_CNT)) u_enc (
    .vec   (pend_q & mask_q),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // set sources are OR-ed in after clears so an edge or SET beats CLEAR/ack on the same bit
  always_comb begin
    irq_d   = irq_i;
    edge_v  = irq_i & ~irq_q;
    id_oh   = IRQ_CNT'(1) << id_q;
    set_v   = edge_v | (wr && off == REG_SET ? wdata : '0);
    clr_v   = (wr && off == REG_CLR ? wdata : '0) | (state_q == REQ && irq_ack_i ? id_oh : '0);
    pend_d  = (pend_q & ~clr_v) | set_v;
    mask_d  = wr && off == REG_MASK ? wdata : mask_q;
    act_v   = pend_d & mask_d & id_oh;
    id_d    = state_q == IDLE && enc_vld ? enc_idx : id_q;
    state_d = state_q == IDLE ? (enc_vld ? REQ : IDLE)
                              : (irq_ack_i || act_v == '0 ? IDLE : REQ);
  end

  always_comb begin
    rdata = off == REG_MASK ? 32'(mask_q) :
            off == REG_PEND ? 32'(pend_q) :
            off == REG_ID   ? {state_q == REQ, (31 - IRQ_ID_W)'(0), id_q} : '0;
    PRDATA = acc && !PWRITE && !bad ? rdata : '0;
  end

  assign PREADY   = 1'b1;
  assign PSLVERR  = bad;
  assign irq_o    = state_q == REQ;
  assign irq_id_o = id_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mask_q  <= '0;
      pend_q  <= '0;
      irq_q   <= '0;
      id_q    <= '0;
      state_q <= IDLE;
    end else begin
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_apb_irq_ctrl.sv
// tb_apb_irq_ctrl: directed checks of the APB interrupt controller
module tb_apb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [3:0]  irq_i = '0;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack = 1'b0;
  int          vectors = 0;
  int          errs = 0;

  apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .IRQ_CNT(4)) dut (
    .HCLK      (clk),
    .HRESET    (rst),
    .PADDR     (paddr),
    .PWDATA    (pwdata),
    .PWRITE    (pwrite),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr),
    .irq_i     (irq_i),
    .irq_o     (irq_o),
    .irq_id_o  (irq_id_o),
    .irq_ack_i (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic err);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    #1;
    chk(tag, 32'(pslverr), 32'(err));
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic err);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    chk(tag, prdata, exp);
    chk({tag, "_err"}, 32'(pslverr), 32'(err));
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_irq_o", 32'(irq_o), 32'd0);
    chk("rst_id", 32'(irq_id_o), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pready", 32'(pready), 32'd1);
    rst = 1'b0;
    apb_rd("rst_mask", 12'h000, 32'h0, 1'b0);
    apb_rd("rst_pend", 12'h004, 32'h0, 1'b0);
    // single edge on line 2 served two cycles later
    apb_wr("wr_mask_f", 12'h000, 32'hF, 1'b0);
    irq_i = 4'b0100;
    tick();
    apb_rd("t1_pend", 12'h004, 32'h4, 1'b0);
    chk("t1_irq_o_early", 32'(irq_o), 32'd0);
    tick();
    chk("t1_irq_o", 32'(irq_o), 32'd1);
    chk("t1_id", 32'(irq_id_o), 32'd2);
    apb_rd("t1_id_reg", 12'h010, 32'h8000_0002, 1'b0);
    ack();
    chk("t1_ack_irq_o", 32'(irq_o), 32'd0);
    chk("t1_ack_id_hold", 32'(irq_id_o), 32'd2);
    apb_rd("t1_ack_pend", 12'h004, 32'h0, 1'b0);
    tick();
    chk("t1_level_no_edge", 32'(irq_o), 32'd0);
    // lines 3 and 1 together: id 1 first, one idle cycle, then id 3
    irq_i = 4'b1110;
    tick();
    apb_rd("t2_pend", 12'h004, 32'hA, 1'b0);
    tick();
    chk("t2_irq_o_a", 32'(irq_o), 32'd1);
    chk("t2_id_a", 32'(irq_id_o), 32'd1);
    ack();
    chk("t2_gap_irq_o", 32'(irq_o), 32'd0);
    apb_rd("t2_pend_b", 12'h004, 32'h8, 1'b0);
    tick();
    chk("t2_irq_o_b", 32'(irq_o), 32'd1);
    chk("t2_id_b", 32'(irq_id_o), 32'd3);
    ack();
    chk("t2_done", 32'(irq_o), 32'd0);
    irq_i = 4'b0000;
    tick();
    // masked line stays pending until unmasked
    apb_wr("wr_mask_0", 12'h000, 32'h0, 1'b0);
    irq_i = 4'b0001;
    tick();
    apb_rd("t3_pend", 12'h004, 32'h1, 1'b0);
    tick();
    chk("t3_masked", 32'(irq_o), 32'd0);
    apb_wr("wr_mask_1", 12'h000, 32'h1, 1'b0);
    chk("t3_unmask_lat", 32'(irq_o), 32'd0);
    tick();
    chk("t3_irq_o", 32'(irq_o), 32'd1);
    chk("t3_id", 32'(irq_id_o), 32'd0);
    ack();
    apb_rd("t3_pend_done", 12'h004, 32'h0, 1'b0);
    // CLEAR withdraws a live request; CLEAR loses against a coincident edge
    apb_wr("wr_mask_f2", 12'h000, 32'hF, 1'b0);
    irq_i = 4'b0101;
    tick();
    tick();
    chk("t4_irq_o", 32'(irq_o), 32'd1);
    chk("t4_id", 32'(irq_id_o), 32'd2);
    apb_wr("wr_clr_4", 12'h008, 32'h4, 1'b0);
    chk("t4_withdrawn", 32'(irq_o), 32'd0);
    apb_rd("t4_pend", 12'h004, 32'h0, 1'b0);
    irq_i = 4'b0001;
    tick();
    irq_i = 4'b0101;
    apb_wr("wr_clr_race", 12'h008, 32'h4, 1'b0);
    apb_rd("t4_race_pend", 12'h004, 32'h4, 1'b0);
    tick();
    chk("t4_race_irq_o", 32'(irq_o), 32'd1);
    ack();
    chk("t4_race_done", 32'(irq_o), 32'd0);
    // error accesses
    apb_rd("t5_rd_14", 12'h014, 32'h0, 1'b1);
    apb_rd("t5_rd_1c", 12'h01C, 32'h0, 1'b1);
    apb_wr("t5_wr_pend", 12'h004, 32'hF, 1'b1);
    apb_rd("t5_pend_kept", 12'h004, 32'h0, 1'b0);
    apb_wr("t5_wr_id", 12'h010, 32'h3, 1'b1);
    apb_wr("t5_wr_18", 12'h018, 32'h0, 1'b1);
    apb_rd("t5_mask_kept", 12'h000, 32'hF, 1'b0);
    // SET, withdraw by MASK, ack ignored in IDLE
    apb_wr("wr_set_8", 12'h00C, 32'h8, 1'b0);
    apb_rd("t6_pend", 12'h004, 32'h8, 1'b0);
    tick();
    chk("t6_irq_o", 32'(irq_o), 32'd1);
    chk("t6_id", 32'(irq_id_o), 32'd3);
    apb_wr("wr_mask_7", 12'h000, 32'h7, 1'b0);
    chk("t6_mask_withdraw", 32'(irq_o), 32'd0);
    ack();
    apb_rd("t6_idle_ack", 12'h004, 32'h8, 1'b0);
    chk("t6_idle_irq_o", 32'(irq_o), 32'd0);
    // reset mid-request; line held high across reset counts once
    apb_wr("wr_mask_f3", 12'h000, 32'hF, 1'b0);
    tick();
    chk("t7_irq_o", 32'(irq_o), 32'd1);
    rst = 1'b1;
    irq_i = 4'b0011;
    tick();
    chk("t7_rst_irq_o", 32'(irq_o), 32'd0);
    chk("t7_rst_id", 32'(irq_id_o), 32'd0);
    apb_rd("t7_rst_mask", 12'h000, 32'h0, 1'b0);
    apb_rd("t7_rst_pend", 12'h004, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    apb_rd("t7_post_pend", 12'h004, 32'h3, 1'b0);
    apb_wr("wr_clr_3", 12'h008, 32'h3, 1'b0);
    tick();
    apb_rd("t7_once", 12'h004, 32'h0, 1'b0);
    chk("t7_irq_o_end", 32'(irq_o), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
